// File: rtl/jtag_pkg.sv
// Shared JTAG instruction-register definitions: default IR width, opcode map,
// one-hot select indices and a helper that turns an index into a select vector.
package jtag_pkg;

  localparam int JTAG_IR_WIDTH   = 4;
  localparam int JTAG_INST_COUNT = 10;

  localparam logic [31:0] OP_EXTEST         = 32'h0;
  localparam logic [31:0] OP_IDCODE         = 32'h1;
  localparam logic [31:0] OP_SAMPLE_PRELOAD = 32'h2;
  localparam logic [31:0] OP_INTEST         = 32'h3;
  localparam logic [31:0] OP_CLAMP          = 32'h4;
  localparam logic [31:0] OP_HALT           = 32'h8;
  localparam logic [31:0] OP_STEP           = 32'h9;
  localparam logic [31:0] OP_RESUME         = 32'hA;
  localparam logic [31:0] OP_RESET          = 32'hB;
  // BYPASS is all-ones at whatever IR width is instantiated; this is the default-width value.
  localparam logic [JTAG_IR_WIDTH-1:0] OP_BYPASS = '1;

  typedef enum logic [3:0] {
    IDX_BYPASS,
    IDX_EXTEST,
    IDX_IDCODE,
    IDX_SAMPLE_PRELOAD,
    IDX_INTEST,
    IDX_CLAMP,
    IDX_HALT,
    IDX_STEP,
    IDX_RESUME,
    IDX_RESET
  } inst_idx_e;

  function automatic logic [JTAG_INST_COUNT-1:0] inst_onehot(input inst_idx_e idx);
    return JTAG_INST_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/jtag_ir_decoder.sv
// Combinational opcode decoder: raw IR value to one-hot instruction select plus
// an "unknown opcode" flag. Anything not in the opcode map selects BYPASS.
module jtag_ir_decoder
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH   = JTAG_IR_WIDTH,
  parameter int INST_COUNT = JTAG_INST_COUNT
) (
  input  logic [IR_WIDTH-1:0]   i_opcode,
  output logic [INST_COUNT-1:0] o_instructions,
  output logic                  o_invalid
);

  localparam int OPW = (IR_WIDTH > 32) ? IR_WIDTH : 32;

  logic [OPW-1:0] w_opcode;
  inst_idx_e      w_idx;
  logic           w_invalid;

  assign w_opcode = OPW'(i_opcode);

  // All-ones is checked first so narrow IRs (e.g. width 2, where 3 is also INTEST) still bypass.
  always_comb begin
    w_idx     = IDX_BYPASS;
    w_invalid = 1'b0;
    if (&i_opcode) begin
      w_idx = IDX_BYPASS;
    end else begin
      case (w_opcode)
        OPW'(OP_EXTEST):         w_idx = IDX_EXTEST;
        OPW'(OP_IDCODE):         w_idx = IDX_IDCODE;
        OPW'(OP_SAMPLE_PRELOAD): w_idx = IDX_SAMPLE_PRELOAD;
        OPW'(OP_INTEST):         w_idx = IDX_INTEST;
        OPW'(OP_CLAMP):          w_idx = IDX_CLAMP;
        OPW'(OP_HALT):           w_idx = IDX_HALT;
        OPW'(OP_STEP):           w_idx = IDX_STEP;
        OPW'(OP_RESUME):         w_idx = IDX_RESUME;
        OPW'(OP_RESET):          w_idx = IDX_RESET;
        default: begin
          w_idx     = IDX_BYPASS;
          w_invalid = 1'b1;
        end
      endcase
    end
  end

  // INST_COUNT must be at least JTAG_INST_COUNT for the select to stay one-hot.
  assign o_instructions = INST_COUNT'(inst_onehot(w_idx));
  assign o_invalid      = w_invalid;

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift on posedge tck, tdo and
// instruction update on negedge tck, all qualified by TAP state enables.
module jtag_ir_param
  import jtag_pkg::*;
#(
  parameter int  IR_WIDTH       = JTAG_IR_WIDTH,
  parameter int  INST_COUNT     = JTAG_INST_COUNT,
  parameter bit  STATUS_CAPTURE = 1'b1,
  localparam int STATUS_W       = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1
) (
  input  logic                  tck,
  input  logic                  tl_reset,
  input  logic                  tdi,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic [STATUS_W-1:0]   status_in,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [INST_COUNT-1:0] instructions,
  output logic [IR_WIDTH-1:0]   ir_opcode,
  output logic                  ir_invalid
);

  logic [IR_WIDTH-1:0]   r_shift;
  logic                  r_tdo;
  logic                  r_tdo_en;
  logic [IR_WIDTH-1:0]   r_opcode;
  logic [INST_COUNT-1:0] r_inst;
  logic                  r_invalid;

  logic [IR_WIDTH-1:0]   w_capture;
  logic [INST_COUNT-1:0] w_dec_inst;
  logic                  w_dec_invalid;

  // A 2-bit IR has no room for status; its status_in port is a dummy bit.
  generate
    if (IR_WIDTH > 2) begin : g_status
      logic [STATUS_W-1:0] w_status;
      assign w_status  = STATUS_CAPTURE ? status_in : '0;
      assign w_capture = {w_status, 2'b01};
    end else begin : g_no_status
      assign w_capture = 2'b01;
    end
  endgenerate

  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      r_shift <= IR_WIDTH'(2'b01);
    end else if (capture_ir) begin
      r_shift <= w_capture;
    end else if (shift_ir) begin
      r_shift <= {tdi, r_shift[IR_WIDTH-1:1]};
    end
  end

  jtag_ir_decoder #(
    .IR_WIDTH   (IR_WIDTH),
    .INST_COUNT (INST_COUNT)
  ) u_decoder (
    .i_opcode       (r_shift),
    .o_instructions (w_dec_inst),
    .o_invalid      (w_dec_invalid)
  );

  // Negedge stage: tdo stays stable across the next posedge, and the update
  // lands half a cycle into Update-IR, sampling the value left by the posedge.
  always_ff @(negedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      r_tdo     <= 1'b0;
      r_tdo_en  <= 1'b0;
      r_opcode  <= IR_WIDTH'(OP_IDCODE);
      r_inst    <= INST_COUNT'(inst_onehot(IDX_IDCODE));
      r_invalid <= 1'b0;
    end else begin
      r_tdo    <= r_shift[0];
      r_tdo_en <= shift_ir;
      if (update_ir) begin
        r_opcode  <= r_shift;
        r_inst    <= w_dec_inst;
        r_invalid <= w_dec_invalid;
      end
    end
  end

  assign tdo          = r_tdo;
  assign tdo_en       = r_tdo_en;
  assign instructions = r_inst;
  assign ir_opcode    = r_opcode;
  assign ir_invalid   = r_invalid;

endmodule

// File: tb/tb_jtag_ir_param.sv
// Scoreboard bench for jtag_ir_param: a 4-bit status-capturing IR and an 8-bit
// zero-capturing IR driven in lockstep, checked against a behavioural model.
module tb_jtag_ir_param;

  logic       tck = 1'b0;
  logic       tl_reset = 1'b1;
  logic       tdi, capture_ir, shift_ir, update_ir;
  logic [1:0] status4;
  logic [5:0] status8;

  logic       tdo4, tdo_en4, inv4;
  logic       tdo8, tdo_en8, inv8;
  logic [9:0] inst4, inst8;
  logic [3:0] opc4;
  logic [7:0] opc8;

  int checks   = 0;
  int failures = 0;

  always #5 tck = ~tck;

  jtag_ir_param #(.IR_WIDTH(4), .INST_COUNT(10), .STATUS_CAPTURE(1'b1)) u_dut4 (
    .tck(tck), .tl_reset(tl_reset), .tdi(tdi), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .status_in(status4),
    .tdo(tdo4), .tdo_en(tdo_en4), .instructions(inst4), .ir_opcode(opc4),
    .ir_invalid(inv4));

  jtag_ir_param #(.IR_WIDTH(8), .INST_COUNT(10), .STATUS_CAPTURE(1'b0)) u_dut8 (
    .tck(tck), .tl_reset(tl_reset), .tdi(tdi), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .status_in(status8),
    .tdo(tdo8), .tdo_en(tdo_en8), .instructions(inst8), .ir_opcode(opc8),
    .ir_invalid(inv8));

  // Behavioural model: IR contents as plain integers, instruction as an index.
  logic [7:0] m_reg [2];
  logic [7:0] m_opc [2];
  int         m_idx [2];
  logic       m_inv [2];

  typedef struct packed {
    logic [1:0]       tdo;
    logic             en;
    logic [1:0][7:0]  opc;
    logic [1:0][9:0]  inst;
    logic [1:0]       inv;
  } exp_t;

  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode map as a lookup table; position+1 is the select index, index 0 is BYPASS.
  function automatic void ref_decode(input logic [7:0] op, input int w,
                                     output int idx, output logic inv);
    int tab [9] = '{0, 1, 2, 3, 4, 8, 9, 10, 11};
    idx = 0;
    inv = 1'b1;
    if (int'(op) == (1 << w) - 1) begin
      inv = 1'b0;
    end else begin
      foreach (tab[i]) if (int'(op) == tab[i]) begin
        idx = i + 1;
        inv = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_reg[d] = 8'h01;
      m_opc[d] = 8'h01;
      m_idx[d] = 2;
      m_inv[d] = 1'b0;
    end
  endfunction

  // One TAP state: inputs change just after posedge, the negedge inside the
  // state shows pre-operation IR bit 0 and any update, the next posedge acts.
  task automatic cycle(input logic cap, input logic sh, input logic upd,
                       input logic ti, input logic [5:0] st);
    exp_t e;
    @(posedge tck);
    #1;
    capture_ir = cap; shift_ir = sh; update_ir = upd; tdi = ti;
    status4 = st[1:0]; status8 = st;
    e = '0;
    e.en = sh;
    for (int d = 0; d < 2; d++) begin
      int w;
      w = (d == 0) ? 4 : 8;
      e.tdo[d] = m_reg[d][0];
      if (upd) begin
        m_opc[d] = m_reg[d];
        ref_decode(m_reg[d], w, m_idx[d], m_inv[d]);
      end
      e.opc[d]  = m_opc[d];
      e.inst[d] = 10'(1) << m_idx[d];
      e.inv[d]  = m_inv[d];
      if (cap)     m_reg[d] = (d == 0) ? {4'b0, st[1:0], 2'b01} : 8'h01;
      else if (sh) m_reg[d] = (m_reg[d] >> 1) | (8'(ti) << (w - 1));
    end
    q.push_back(e);
  endtask

  task automatic load(input logic [7:0] v);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, v[i], 6'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 6'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_inst4", 32'(inst4), 32'h4);
    chk("rst_opc4", 32'(opc4), 32'h1);
    chk("rst_inv4", 32'(inv4), 32'h0);
    chk("rst_tdo4", 32'(tdo4), 32'h0);
    chk("rst_en4", 32'(tdo_en4), 32'h0);
    chk("rst_inst8", 32'(inst8), 32'h4);
    chk("rst_opc8", 32'(opc8), 32'h1);
    chk("rst_inv8", 32'(inv8), 32'h0);
    chk("rst_tdo8", 32'(tdo8), 32'h0);
    chk("rst_en8", 32'(tdo_en8), 32'h0);
  endtask

  task automatic reset_mid_shift();
    @(posedge tck);
    #1;
    capture_ir = 1'b0; shift_ir = 1'b1; update_ir = 1'b0; tdi = 1'b1;
    #2 tl_reset = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    @(posedge tck);
    #1;
    shift_ir = 1'b0; tdi = 1'b0;
    @(posedge tck);
    #1 tl_reset = 1'b1;
  endtask

  // Monitor: every negedge with a pending expectation is compared in full.
  always @(negedge tck) begin
    #1;
    if (tl_reset === 1'b1 && q.size() > 0) begin
      me = q.pop_front();
      chk("tdo4", 32'(tdo4), 32'(me.tdo[0]));
      chk("tdo8", 32'(tdo8), 32'(me.tdo[1]));
      chk("tdo_en4", 32'(tdo_en4), 32'(me.en));
      chk("tdo_en8", 32'(tdo_en8), 32'(me.en));
      chk("inst4", 32'(inst4), 32'(me.inst[0]));
      chk("inst8", 32'(inst8), 32'(me.inst[1]));
      chk("opc4", 32'(opc4), 32'(me.opc[0][3:0]));
      chk("opc8", 32'(opc8), 32'(me.opc[1]));
      chk("inv4", 32'(inv4), 32'(me.inv[0]));
      chk("inv8", 32'(inv8), 32'(me.inv[1]));
    end
  end

  initial begin
    logic [3:0] valid_ops [10];
    valid_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
    tdi = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    status4 = '0; status8 = '0;
    model_reset();
    #2 tl_reset = 1'b0;
    #2 chk_reset_vals();
    @(posedge tck);
    #1 tl_reset = 1'b1;

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
    // Capture status 2'b10 and shift it out with tdi=0.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'b000010);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'b000010);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
    load(8'h22);
    load(8'h66);
    load(8'hFF);
    // Capture beats shift; no update, so instructions must hold.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 6'h3F);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
    // Pass-through latency on both widths.
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'($urandom), 6'h0);
    // Update concurrent with shift latches the pre-shift value.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 6'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 6'h0);
    reset_mid_shift();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);

    for (int n = 0; n < 30; n++)
      load({4'($urandom), valid_ops[$urandom_range(0, 9)]});
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      cycle(r == 0 || r == 8, (r >= 1 && r <= 5) || r == 7 || r == 8,
            r == 6 || r == 7, 1'($urandom), 6'($urandom));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge tck);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
